// File: rtl/dp_ex_wb_skid_register.sv
// EX->WB pipeline register with valid/ready handshake and one-entry skid buffer.
// Optional stall counter output enabled by defining DP_SKID_STALL_COUNT_EN.
module dp_ex_wb_skid_register #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int LANES  = 8,
    parameter int LANE_W = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADDR_W-1:0]         A3_E,
    input  logic [ADDR_W-1:0]         A4_E,
    input  logic [DATA_W-1:0]         OpB_E,
    input  logic [DATA_W-1:0]         ALUResultE,
    input  logic [DATA_W-1:0]         PCNextE,
    input  logic [LANES*LANE_W-1:0]   popcnt_E,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR_W-1:0]         A3_W,
    output logic [ADDR_W-1:0]         A4_W,
    output logic [DATA_W-1:0]         RD2_W,
    output logic [DATA_W-1:0]         ALUResultW,
    output logic [DATA_W-1:0]         PCNextW,
    output logic [LANES*LANE_W-1:0]   popcnt_W
`ifdef DP_SKID_STALL_COUNT_EN
    ,
    output logic [15:0]               stall_cnt
`endif
);

    localparam int PW = 2*ADDR_W + 3*DATA_W + LANES*LANE_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_n;
    logic [PW-1:0] r_main;
    logic [PW-1:0] r_skid;
    logic [PW-1:0] w_in_pl;
    logic          w_ld_main_in;
    logic          w_ld_main_skid;
    logic          w_ld_skid;

    assign w_in_pl = {A3_E, A4_E, OpB_E, ALUResultE, PCNextE, popcnt_E};

    // in_ready depends on registered state only, never on out_ready
    assign in_ready  = reset & (r_state != SKID);
    assign out_valid = (r_state != EMPTY);

    assign {A3_W, A4_W, RD2_W, ALUResultW, PCNextW, popcnt_W} = r_main;

    always_comb begin
        w_state_n      = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        unique case (r_state)
            EMPTY: begin
                if (in_valid) begin
                    w_ld_main_in = 1'b1;
                    w_state_n    = FULL;
                end
            end
            FULL: begin
                if (out_ready && in_valid) begin
                    w_ld_main_in = 1'b1;
                end else if (out_ready) begin
                    w_state_n = EMPTY;
                end else if (in_valid) begin
                    w_ld_skid = 1'b1;
                    w_state_n = SKID;
                end
            end
            SKID: begin
                if (out_ready) begin
                    w_ld_main_skid = 1'b1;
                    w_state_n      = FULL;
                end
            end
            default: begin
                w_state_n = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else if (flush) begin
            // zeroed addresses make WB perform no register write
            r_state <= EMPTY;
            r_main  <= '0;
        end else begin
            r_state <= w_state_n;
            if (w_ld_main_in) begin
                r_main <= w_in_pl;
            end else if (w_ld_main_skid) begin
                r_main <= r_skid;
            end
            if (w_ld_skid) begin
                r_skid <= w_in_pl;
            end
        end
    end

`ifdef DP_SKID_STALL_COUNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_dp_ex_wb_skid_register.sv
// Scoreboard bench for dp_ex_wb_skid_register (LANES=4, LANE_W=4).
// Accepted bundles are queued; a negedge monitor pops and compares on output transfer.
module tb_dp_ex_wb_skid_register;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int LN = 4;
    localparam int LW = 4;

    typedef struct packed {
        logic [AW-1:0]    a3;
        logic [AW-1:0]    a4;
        logic [DW-1:0]    opb;
        logic [DW-1:0]    alu;
        logic [DW-1:0]    pcn;
        logic [LN*LW-1:0] pop;
    } bun_t;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [AW-1:0]    A3_E;
    logic [AW-1:0]    A4_E;
    logic [DW-1:0]    OpB_E;
    logic [DW-1:0]    ALUResultE;
    logic [DW-1:0]    PCNextE;
    logic [LN*LW-1:0] popcnt_E;
    logic             out_valid;
    logic             out_ready;
    logic [AW-1:0]    A3_W;
    logic [AW-1:0]    A4_W;
    logic [DW-1:0]    RD2_W;
    logic [DW-1:0]    ALUResultW;
    logic [DW-1:0]    PCNextW;
    logic [LN*LW-1:0] popcnt_W;
`ifdef DP_SKID_STALL_COUNT_EN
    logic [15:0]      stall_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    bun_t q[$];

    dp_ex_wb_skid_register #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .LANES (LN),
        .LANE_W(LW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A3_E      (A3_E),
        .A4_E      (A4_E),
        .OpB_E     (OpB_E),
        .ALUResultE(ALUResultE),
        .PCNextE   (PCNextE),
        .popcnt_E  (popcnt_E),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A3_W      (A3_W),
        .A4_W      (A4_W),
        .RD2_W     (RD2_W),
        .ALUResultW(ALUResultW),
        .PCNextW   (PCNextW),
        .popcnt_W  (popcnt_W)
`ifdef DP_SKID_STALL_COUNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", n, a, e);
        end
    endtask

    // monitor: compare at output transfer, then record input transfer
    always @(negedge clk) begin
        bun_t got;
        bun_t exp;
        if (!reset) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                got = '{A3_W, A4_W, RD2_W, ALUResultW, PCNextW, popcnt_W};
                if (q.size() == 0) begin
                    chk("unexpected_bundle", 128'(got), 128'(0));
                end else begin
                    exp = q.pop_front();
                    chk("bundle", 128'(got), 128'(exp));
                end
            end
            if (flush) begin
                q.delete();
            end else if (in_valid && in_ready) begin
                q.push_back('{A3_E, A4_E, OpB_E, ALUResultE, PCNextE, popcnt_E});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [AW-1:0] a3, input logic [AW-1:0] a4,
                         input logic [DW-1:0] alu, input logic [LN*LW-1:0] pop);
        in_valid   = 1'b1;
        A3_E       = a3;
        A4_E       = a4;
        OpB_E      = alu ^ 32'h5555_0000;
        ALUResultE = alu;
        PCNextE    = alu + 32'h100;
        popcnt_E   = pop;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [LN*LW-1:0] lane;
        reset     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(5'd1, 5'd2, 32'hDEADBEEF, 16'h1234);
        #1;
        chk("rst_in_ready_low", 128'(in_ready), 128'(0));
        repeat (3) cyc();
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_alu", 128'(ALUResultW), 128'(0));
        chk("rst_fields", 128'({A3_W, A4_W, RD2_W, PCNextW, popcnt_W}), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("post_rst_in_ready", 128'(in_ready), 128'(1));
        cyc();

        // streaming at full throughput
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(5'(i), 5'(i + 10), 32'(i), 16'(i * 3));
            chk("stream_in_ready", 128'(in_ready), 128'(1));
            cyc();
            chk("stream_alu", 128'(ALUResultW), 128'(i));
        end
        in_valid = 1'b0;
        cyc();
        chk("stream_empty", 128'(out_valid), 128'(0));

        // skid fill and drain
        drive(5'd5, 5'd0, 32'h50, 16'h0);
        cyc();
        drive(5'd6, 5'd0, 32'h60, 16'h0);
        cyc();
        out_ready = 1'b0;
        drive(5'd7, 5'd0, 32'h70, 16'h0);
        cyc();
        chk("skid_in_ready", 128'(in_ready), 128'(0));
        chk("skid_hold_a3", 128'(A3_W), 128'(6));
        drive(5'd8, 5'd0, 32'h80, 16'h0);
        repeat (2) cyc();
        chk("skid_stable_a3", 128'(A3_W), 128'(6));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc();
        chk("drain_a3", 128'(A3_W), 128'(7));
        chk("drain_in_ready", 128'(in_ready), 128'(1));
        cyc();
        chk("drain_empty", 128'(out_valid), 128'(0));

        // flush while both entries valid
        out_ready = 1'b0;
        drive(5'd9, 5'd3, 32'h90, 16'h0);
        cyc();
        drive(5'd10, 5'd4, 32'hA0, 16'h0);
        cyc();
        chk("fl_skid_full", 128'(in_ready), 128'(0));
        flush = 1'b1;
        drive(5'd11, 5'd5, 32'hB0, 16'h0);
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", 128'(out_valid), 128'(0));
        chk("fl_addrs", 128'({A3_W, A4_W}), 128'(0));
        chk("fl_in_ready", 128'(in_ready), 128'(1));
        out_ready = 1'b1;
        repeat (3) cyc();
        chk("fl_stays_empty", 128'(out_valid), 128'(0));

        // lane packing
        drive(5'd12, 5'd1, 32'hC0, 16'hA5C3);
        cyc();
        in_valid = 1'b0;
        lane = popcnt_W;
        chk("lane_word", 128'(popcnt_W), 128'(16'hA5C3));
        chk("lane0", 128'(lane[3:0]), 128'(4'h3));
        chk("lane3", 128'(lane[15:12]), 128'(4'hA));
        cyc();

`ifdef DP_SKID_STALL_COUNT_EN
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        out_ready = 1'b0;
        drive(5'd13, 5'd2, 32'hD0, 16'h0);
        cyc();
        in_valid = 1'b0;
        chk("stall_start", 128'(stall_cnt), 128'(0));
        repeat (10) cyc();
        chk("stall_10", 128'(stall_cnt), 128'(10));
        out_ready = 1'b1;
        flush     = 1'b1;
        cyc();
        flush = 1'b0;
        chk("stall_after_flush", 128'(stall_cnt), 128'(10));
        out_ready = 1'b0;
        drive(5'd14, 5'd2, 32'hE0, 16'h0);
        cyc();
        in_valid = 1'b0;
        repeat (65530) cyc();
        chk("stall_sat", 128'(stall_cnt), 128'(16'hFFFF));
        cyc();
        chk("stall_sat_hold", 128'(stall_cnt), 128'(16'hFFFF));
        out_ready = 1'b1;
`endif

        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) cyc();
        chk("queue_drained", 128'(q.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
